capture_readout: RTL and testbench

- Downstream stage of the logic-capture block.
- After a capture finishes, reads the captured samples back out of the sample BRAM, from a start address through an end address inclusive, wrapping at the top of memory.
- Delivers them as a byte stream with a valid/ready handshake to the host-link transmitter.
- Absorbs BRAM read latency and downstream backpressure with a 2-entry buffer, sustaining 1 byte/clock.

---
 rtl/capture_pkg.sv | 8 +
 rtl/capture_readout_if.sv | 16 +
 rtl/readout_fifo.sv | 27 ++
 rtl/capture_readout.sv | 98 +++++++++
 tb/tb_capture_readout.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared widths, readout states and header size for the capture readout path.
package capture_pkg;
   localparam int ADDR_W_DEF = 18;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF = ADDR_W_DEF + 1;
   localparam int HDR_BYTES = 3;
   typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, READ = 2'd2, DRAIN = 2'd3} rd_state_e;
endpackage

// File: rtl/capture_readout_if.sv
// capture_readout_if: BRAM read port plus outgoing byte stream of the capture readout.
interface capture_readout_if
   import capture_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              bram_en;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_rddata;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   modport master (output bram_en, bram_addr, m_data, m_valid, input bram_rddata, m_ready);
   modport slave (input bram_en, bram_addr, m_data, m_valid, output bram_rddata, m_ready);
endinterface

// File: rtl/readout_fifo.sv
// readout_fifo: 2-entry FIFO with a registered head word, cleared by reset or flush.
module readout_fifo #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              wr,
   input  logic [DATA_W-1:0] din,
   input  logic              rd,
   output logic [DATA_W-1:0] head,
   output logic [1:0]        count
);
   logic [DATA_W-1:0] tail;
   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         count <= count + 2'(wr) - 2'(rd);
         if (wr && (count == 2'd0 || (rd && count == 2'd1))) head <= din;
         else if (rd && count == 2'd2) head <= tail;
         if (wr && (count == 2'd2 || (!rd && count == 2'd1))) tail <= din;
      end
   end
endmodule

// File: rtl/capture_readout.sv
// capture_readout: streams BRAM words start_addr..end_addr (inclusive, wrapping) as valid/ready beats.
// Define READOUT_HEADER_EN to prefix each readout with a 3-byte little-endian beat count.
module capture_readout
   import capture_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic              busy,
   output logic              done,
   capture_readout_if.master bus
);
   localparam int CW = ADDR_W + 1;
   localparam logic [1:0] S_IDLE = IDLE, S_READ = READ, S_DRAIN = DRAIN;
   logic [1:0] state, fifo_count;
   logic [ADDR_W-1:0] addr, diff;
   logic [CW-1:0] reads_rem, beats_in;
   logic [2:0] base, occ;
   logic [DATA_W-1:0] hdr_byte;
   logic en_d1, pop, issue, last, hdr_push, hdr_last;
   assign diff = end_addr - start_addr;
   assign beats_in = {1'b0, diff} + CW'(1);
   assign pop = bus.m_valid & bus.m_ready;
   // Occupancy the FIFO will reach once everything already committed lands; a new read needs room for one more.
   assign base = 3'(fifo_count) + 3'(en_d1) - 3'(pop);
   assign occ = base + 3'(hdr_push);
   assign issue = !abort && reads_rem != '0 && occ < 3'd2 && (state == S_READ || hdr_last);
   assign last = state == S_DRAIN && fifo_count == 2'd1 && pop && !en_d1;
   assign busy = state != S_IDLE;
   assign bus.bram_en = issue;
   assign bus.bram_addr = addr;
   assign bus.m_valid = fifo_count != 2'd0;
`ifdef READOUT_HEADER_EN
   localparam logic [1:0] S_HDR = HDR;
   localparam logic [1:0] S_FIRST = S_HDR;
   logic [1:0] hdr_idx;
   logic [CW-1:0] beats;
   // The first read overlaps the final header byte so samples follow without a bubble.
   assign hdr_push = state == S_HDR && base < 3'd2;
   assign hdr_last = hdr_push && hdr_idx == 2'(HDR_BYTES - 1);
   assign hdr_byte = DATA_W'(beats >> {hdr_idx, 3'b000});
   always_ff @(posedge clk) begin
      if (!resetn || abort) begin
         hdr_idx <= '0;
         beats <= '0;
      end else if (state == S_IDLE && start) begin
         hdr_idx <= '0;
         beats <= beats_in;
      end else if (hdr_push) hdr_idx <= hdr_idx + 2'd1;
   end
`else
   localparam logic [1:0] S_FIRST = S_READ;
   assign hdr_push = 1'b0;
   assign hdr_last = 1'b0;
   assign hdr_byte = '0;
`endif
   always_ff @(posedge clk) begin
      if (!resetn || abort) begin
         state <= S_IDLE;
         addr <= '0;
         reads_rem <= '0;
         en_d1 <= 1'b0;
         done <= 1'b0;
      end else begin
         en_d1 <= issue;
         done <= last;
         if (state == S_IDLE && start) begin
            state <= S_FIRST;
            addr <= start_addr;
            reads_rem <= beats_in;
         end else begin
            if (issue) begin
               addr <= addr + ADDR_W'(1);
               reads_rem <= reads_rem - CW'(1);
            end
            if (issue && reads_rem == CW'(1)) state <= S_DRAIN;
            else if (hdr_last) state <= S_READ;
            else if (last) state <= S_IDLE;
         end
      end
   end
   readout_fifo #(.DATA_W(DATA_W)) u_fifo (
      .clk(clk),
      .resetn(resetn),
      .flush(abort),
      .wr(en_d1 | hdr_push),
      .din(hdr_push ? hdr_byte : bus.bram_rddata),
      .rd(pop),
      .head(bus.m_data),
      .count(fifo_count)
   );
endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout: table-driven and randomized readouts checked against a queue-based stream model.
module tb_capture_readout;
   import capture_pkg::*;
   localparam int AW = ADDR_W_DEF;
   localparam int DW = DATA_W_DEF;
`ifdef READOUT_HEADER_EN
   localparam int HN = HDR_BYTES;
   localparam int EXP_EN = 2;
   localparam int EXP_V = 1;
`else
   localparam int HN = 0;
   localparam int EXP_EN = 0;
   localparam int EXP_V = 2;
`endif
   typedef struct {
      logic [AW-1:0] s;
      logic [AW-1:0] e;
      int mode;
      int poke;
      int abort_at;
      int samples;
   } vec_t;
   logic clk = 1'b0;
   logic resetn, start, abort, busy, done;
   logic [AW-1:0] start_addr, end_addr;
   int checks = 0;
   int errors = 0;
   vec_t tbl[8];
   capture_readout_if bus ();
   capture_readout dut (
      .clk(clk),
      .resetn(resetn),
      .start(start),
      .abort(abort),
      .start_addr(start_addr),
      .end_addr(end_addr),
      .busy(busy),
      .done(done),
      .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
      return a[7:0] ^ {a[15:12], a[17:14]} ^ 8'h3C;
   endfunction
   always_ff @(posedge clk) if (bus.bram_en) bus.bram_rddata <= mem(bus.bram_addr);
   always @(negedge clk) begin
      if (resetn && (dut.fifo_count > 2'd2 || (done && bus.m_valid))) begin
         errors++;
         $display("FAIL monitor: fifo_count=%0d done=%b m_valid=%b, required fifo_count<=2 and not both", dut.fifo_count, done, bus.m_valid);
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] e, input int mode, input int poke, input int abort_at, input int samples);
      logic [DW-1:0] q[$];
      logic [AW-1:0] aq[$];
      logic [DW-1:0] held;
      logic stalled;
      int n, nq, bi, ai, first_en, first_v, bubbles;
      bit fin;
      n = int'(AW'(e - s)) + 1;
      for (int i = 0; i < HN; i++) q.push_back(DW'(n >> (8 * i)));
      nq = n > 400 ? 400 : n;
      for (int i = 0; i < nq; i++) begin
         aq.push_back(s + AW'(i));
         q.push_back(mem(s + AW'(i)));
      end
      bi = 0; ai = 0; first_en = -1; first_v = -1; bubbles = 0; stalled = 0; fin = 0; held = '0;
      start_addr = s; end_addr = e; start = 1'b1;
      tick();
      for (int k = 0; k < 8 * nq + 60 && !fin; k++) begin
         start = k == poke;
         if (k == poke) begin
            start_addr = s + AW'(18'h155);
            end_addr = s + AW'(3);
         end
         bus.m_ready = mode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
         if (abort_at >= 0 && bi == abort_at) begin
            abort = 1'b1;
            bus.m_ready = 1'b0;
         end
         #1;
         if (k == 0) begin
            chk("count_latch", 32'(dut.reads_rem), n);
            chk("busy_after_start", busy, 1);
         end
         if (bus.bram_en) begin
            if (first_en < 0) first_en = k;
            if (ai < nq) chk("bram_addr", bus.bram_addr, aq[ai]);
            ai++;
         end
         if (stalled) begin
            chk("stall_valid", bus.m_valid, 1);
            chk("stall_data", bus.m_data, held);
         end
         if (bus.m_valid && first_v < 0) first_v = k;
         if (mode == 0 && first_v >= 0 && bi < q.size() && !bus.m_valid) bubbles++;
         if (done) begin
            chk("done_all_beats", bi, q.size());
            chk("busy_at_done", busy, 0);
            fin = 1;
         end
         if (bus.m_valid && bus.m_ready) begin
            if (bi < q.size()) chk("m_data", bus.m_data, q[bi]);
            else chk("extra_beat", bi, q.size());
            bi++;
         end
         stalled = bus.m_valid && !bus.m_ready;
         held = bus.m_data;
         if (abort) begin
            tick();
            abort = 1'b0;
            bus.m_ready = 1'b1;
            #1;
            chk("abort_valid", bus.m_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_en", bus.bram_en, 0);
            chk("abort_done", done, 0);
            for (int j = 0; j < 3; j++) begin
               tick();
               chk("abort_no_done", done, 0);
            end
            fin = 1;
         end else tick();
      end
      start = 1'b0;
      chk("finished", fin, 1);
      if (abort_at < 0) begin
         chk("beats", bi, samples + HN);
         chk("reads", ai, n);
         if (mode == 0) begin
            chk("first_bram_en", first_en, EXP_EN);
            chk("first_valid", first_v, EXP_V);
            chk("bubbles", bubbles, 0);
         end
         chk("done_single", done, 0);
         chk("idle_busy", busy, 0);
      end
   endtask
   initial begin
      tbl[0] = '{18'h00010, 18'h00013, 0, -1, -1, 4};
      tbl[1] = '{18'h3FFFE, 18'h00001, 0, -1, -1, 4};
      tbl[2] = '{18'h00100, 18'h00100, 0, -1, -1, 1};
      tbl[3] = '{18'h00040, 18'h0004F, 1, -1, -1, 16};
      tbl[4] = '{18'h00400, 18'h00409, 0, 4, -1, 10};
      tbl[5] = '{18'h01000, 18'h01063, 0, -1, 5, 100};
      tbl[6] = '{18'h00020, 18'h00021, 0, -1, -1, 2};
      tbl[7] = '{18'h00500, 18'h004FF, 0, -1, 20, 262144};
      resetn = 1'b0; start = 1'b0; abort = 1'b0; start_addr = '0; end_addr = '0; bus.m_ready = 1'b0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bram_en", bus.bram_en, 0);
      chk("rst_bram_addr", bus.bram_addr, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_data", bus.m_data, 0);
      resetn = 1'b1;
      tick();
      start_addr = 18'h00200; end_addr = 18'h002FF; start = 1'b1; bus.m_ready = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      resetn = 1'b0;
      tick();
      chk("midrst_busy", busy, 0);
      chk("midrst_bram_en", bus.bram_en, 0);
      chk("midrst_bram_addr", bus.bram_addr, 0);
      chk("midrst_m_valid", bus.m_valid, 0);
      chk("midrst_m_data", bus.m_data, 0);
      resetn = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) run(tbl[i].s, tbl[i].e, tbl[i].mode, tbl[i].poke, tbl[i].abort_at, tbl[i].samples);
      for (int r = 0; r < 10; r++) begin
         logic [AW-1:0] s;
         int len;
         s = AW'($urandom);
         len = $urandom_range(0, 40);
         run(s, s + AW'(len), r % 3 == 0 ? 0 : 1, len >= 4 ? int'($urandom_range(1, len)) : -1, -1, len + 1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
